// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine feeding the HI/LO registers.
// One bit per cycle (shift-add multiply, restoring divide) on operand
// magnitudes, followed by one sign-correction cycle.
module mul_div_unit #(
  parameter int unsigned n = 32
) (
  input  logic         clk_port,
  input  logic         rst_port,
  input  logic         start_port,
  input  logic [1:0]   op_port,
  input  logic [n-1:0] a_port,
  input  logic [n-1:0] b_port,
  output logic         busy_port,
  output logic         done_port,
  output logic [n-1:0] hi_port,
  output logic [n-1:0] lo_port
);

  localparam int unsigned CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   count;
  logic            is_div;
  logic            neg_lo;
  logic            neg_hi;
  logic            div_zero;
  logic [n-1:0]    a_lat;
  logic [n-1:0]    divisor;
  logic [2*n-1:0]  work;

  // operand magnitudes (signed ops only take absolute values)
  logic            a_neg;
  logic            b_neg;
  logic [n-1:0]    a_mag;
  logic [n-1:0]    b_mag;

  // one iteration of either algorithm
  logic [n-1:0]    addend;
  logic [n:0]      mul_sum;
  logic [n:0]      rem_sh;
  logic [n:0]      trial;
  logic [2*n-1:0]  step_next;

  // sign-corrected results
  logic [2*n-1:0]  prod_neg;
  logic [n-1:0]    res_hi;
  logic [n-1:0]    res_lo;

  assign a_neg = op_port[0] & a_port[n-1];
  assign b_neg = op_port[0] & b_port[n-1];
  assign a_mag = a_neg ? -a_port : a_port;
  assign b_mag = b_neg ? -b_port : b_port;

  // Multiply: work = {partial product, multiplier}; add divisor-held
  // multiplicand into the upper half when lsb set, then shift right.
  // Divide: work = {remainder, dividend/quotient}; shift left one bit,
  // trial-subtract divisor, keep the difference when non-negative.
  assign addend  = work[0] ? divisor : '0;
  assign mul_sum = {1'b0, work[2*n-1:n]} + {1'b0, addend};
  assign rem_sh  = {work[2*n-1:n], work[n-1]};
  assign trial   = rem_sh - {1'b0, divisor};

  // select the next working value for the active algorithm
  always_comb begin
    step_next = '0;
    if (is_div) begin
      if (trial[n])
        step_next = {rem_sh[n-1:0], work[n-2:0], 1'b0};
      else
        step_next = {trial[n-1:0], work[n-2:0], 1'b1};
    end else begin
      step_next = {mul_sum, work[n-1:1]};
    end
  end

  assign prod_neg = -work;

  // sign fix applied at the SIGN edge; divide-by-zero overrides the path
  always_comb begin
    res_hi = work[2*n-1:n];
    res_lo = work[n-1:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi = a_lat;
        res_lo = '1;
      end else begin
        if (neg_hi) res_hi = -work[2*n-1:n];
        if (neg_lo) res_lo = -work[n-1:0];
      end
    end else if (neg_lo) begin
      res_hi = prod_neg[2*n-1:n];
      res_lo = prod_neg[n-1:0];
    end
  end

  // state register
  always_ff @(posedge clk_port or negedge rst_port) begin
    if (!rst_port) state <= IDLE;
    else           state <= state_nx;
  end

  // next-state and status decode
  always_comb begin
    state_nx  = state;
    busy_port = 1'b0;
    done_port = 1'b0;
    case (state)
      IDLE: if (start_port) state_nx = CALC;
      CALC: begin
        busy_port = 1'b1;
        if (count == LAST) state_nx = SIGN;
      end
      SIGN: begin
        busy_port = 1'b1;
        state_nx  = DONE;
      end
      DONE: begin
        done_port = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // datapath: latch operands, iterate, register results
  always_ff @(posedge clk_port or negedge rst_port) begin
    if (!rst_port) begin
      count    <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      a_lat    <= '0;
      divisor  <= '0;
      work     <= '0;
      hi_port  <= '0;
      lo_port  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_port) begin
            is_div   <= op_port[1];
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= a_neg;
            div_zero <= (b_port == '0);
            a_lat    <= a_port;
            divisor  <= b_mag;
            work     <= {{n{1'b0}}, a_mag};
            count    <= '0;
          end
        end
        CALC: begin
          work  <= step_next;
          count <= (count == LAST) ? '0 : count + CW'(1);
        end
        SIGN: begin
          hi_port <= res_hi;
          lo_port <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed + random bench for mul_div_unit with a result scoreboard.
module tb_mul_div_unit;

  localparam int unsigned N = 32;

  logic          clk_port = 1'b0;
  logic          rst_port;
  logic          start_port;
  logic [1:0]    op_port;
  logic [N-1:0]  a_port;
  logic [N-1:0]  b_port;
  logic          busy_port;
  logic          done_port;
  logic [N-1:0]  hi_port;
  logic [N-1:0]  lo_port;

  int            tests = 0;
  int            fails = 0;
  logic [63:0]   sbq[$];

  mul_div_unit #(.n(N)) dut (
    .clk_port  (clk_port),
    .rst_port  (rst_port),
    .start_port(start_port),
    .op_port   (op_port),
    .a_port    (a_port),
    .b_port    (b_port),
    .busy_port (busy_port),
    .done_port (done_port),
    .hi_port   (hi_port),
    .lo_port   (lo_port)
  );

  always #5 clk_port = ~clk_port;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference result {hi, lo} from plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] res;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      2'b00: res = {32'h0, a} * {32'h0, b};
      2'b01: res = sa * sb;
      default: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else if (op == 2'b10) res = {a % b, a / b};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Issue one operation and wait for its done pulse. With early=1 the
  // caller is sitting in DONE and start is raised there first (must be ignored).
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input int inject, input bit early);
    int cyc;
    int busy_cnt;
    sbq.push_back(exp);
    if (early) begin
      start_port = 1'b1; op_port = op; a_port = a; b_port = b;
      @(negedge clk_port);
      check({tag, " start in DONE ignored"}, {63'h0, busy_port}, 64'h0);
    end else begin
      @(negedge clk_port);
      start_port = 1'b1; op_port = op; a_port = a; b_port = b;
    end
    @(negedge clk_port);
    start_port = 1'b0;
    a_port  = $urandom;
    b_port  = $urandom;
    op_port = 2'($urandom_range(0, 3));
    cyc = 0;
    busy_cnt = 0;
    while (!done_port && cyc < 200) begin
      if (busy_port) busy_cnt++;
      if (cyc == inject) begin
        start_port = 1'b1;
        a_port  = $urandom;
        b_port  = $urandom;
        op_port = 2'($urandom_range(0, 3));
      end else begin
        start_port = 1'b0;
      end
      @(negedge clk_port);
      cyc++;
    end
    start_port = 1'b0;
    check({tag, " latency"}, 64'(cyc), 64'(N + 1));
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'(N + 1));
    check({tag, " busy at done"}, {63'h0, busy_port}, 64'h0);
    check({tag, " result"}, {hi_port, lo_port}, sbq.pop_front());
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    int          done_seen;

    rst_port = 1'b0; start_port = 1'b0; op_port = '0; a_port = '0; b_port = '0;
    #1;
    check("reset outputs", {busy_port, done_port, hi_port, lo_port}, 66'h0);
    repeat (2) @(negedge clk_port);
    rst_port = 1'b1;
    @(negedge clk_port);
    check("idle after reset", {busy_port, done_port, hi_port, lo_port}, 66'h0);

    run_op("MULTU max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1, 1'b0);
    @(negedge clk_port);
    check("done one cycle", {62'h0, busy_port, done_port}, 64'h0);
    check("hi/lo hold", {hi_port, lo_port}, 64'hFFFF_FFFE_0000_0001);

    run_op("MULT -3*5",    2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, -1, 1'b0);
    run_op("MULT -4*-4",   2'b01, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 64'h0000_0000_0000_0010, -1, 1'b0);
    run_op("MULT minneg^2",2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1, 1'b0);
    run_op("DIV -7/2",     2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, -1, 1'b0);
    run_op("DIVU 7/2",     2'b10, 32'h0000_0007, 32'h0000_0002, 64'h0000_0001_0000_0003, -1, 1'b0);
    run_op("DIV overflow", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, -1, 1'b0);
    run_op("DIVU 7/0",     2'b10, 32'h0000_0007, 32'h0000_0000, 64'h0000_0007_FFFF_FFFF, -1, 1'b0);
    run_op("DIV -5/0",     2'b11, 32'hFFFF_FFFB, 32'h0000_0000, 64'hFFFF_FFFB_FFFF_FFFF, -1, 1'b0);

    // start pulse mid-CALC must not disturb the operation in flight
    run_op("MULTU inject", 2'b00, 32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060, 10, 1'b0);

    // back-to-back: start raised while in DONE, accepted on the IDLE edge
    run_op("DIVU 100/7 b2b", 2'b10, 32'd100, 32'd7, 64'h0000_0002_0000_000E, -1, 1'b1);

    // reset mid-operation abandons it with no done pulse
    @(negedge clk_port);
    start_port = 1'b1; op_port = 2'b00; a_port = 32'h1111_1111; b_port = 32'h2222_2222;
    @(negedge clk_port);
    start_port = 1'b0;
    repeat (15) @(negedge clk_port);
    rst_port = 1'b0;
    #1;
    check("async reset outputs", {busy_port, done_port, hi_port, lo_port}, 66'h0);
    done_seen = 0;
    repeat (2) begin
      @(negedge clk_port);
      if (done_port) done_seen++;
    end
    rst_port = 1'b1;
    repeat (3) begin
      @(negedge clk_port);
      if (done_port || busy_port) done_seen++;
    end
    check("no done after abort", 64'(done_seen), 64'h0);
    check("outputs held 0 after abort", {hi_port, lo_port}, 64'h0);

    run_op("DIV -100/7", 2'b11, 32'hFFFF_FF9C, 32'd7, 64'hFFFF_FFFE_FFFF_FFF2, -1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ra  = $urandom;
      rb  = (i == 3) ? 32'h0 : $urandom;
      rop = 2'(i % 4);
      run_op($sformatf("random %0d op%0d", i, rop), rop, ra, rb, model(rop, ra, rb), -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
